// File: rtl/encoder42_reg.sv
// Registered 4-to-2 priority encoder (z > y > x > w) with a valid/ready output
// register, malformed-input flag and saturating error counter.
module encoder42_reg #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A,
  output logic             B,
  output logic             err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_a;
  logic             r_b;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_a;
  logic             w_b;
  logic             w_err;
  logic [2:0]       w_pop;

  always_comb begin
    w_pop = {2'b00, w} + {2'b00, x} + {2'b00, y} + {2'b00, z};
    w_err = (w_pop != 3'd1);
    // Priority code: zero-hot falls through to 00.
    w_a   = z | y;
    w_b   = z | (~y & x);
  end

  assign out_valid = (r_state == FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= FULL;
      r_a     <= w_a;
      r_b     <= w_b;
      r_err   <= w_err;
    end else if (out_ready) begin
      r_state <= EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= (w_accept & w_err) ? CNT_W'(1) : '0;
    end else if (w_accept & w_err & (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign err       = r_err;
  assign err_count = r_cnt;

endmodule

// File: tb/tb_encoder42_reg.sv
// Self-checking bench for encoder42_reg: directed scenarios then random traffic,
// against a behavioural model of the handshake, encoding and error counter.
module tb_encoder42_reg;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, cnt_clr;
  logic       w, x, y, z;
  logic       rdy8, vld8, a8, b8, err8;
  logic       rdy2, vld2, a2, b2, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  encoder42_reg #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .w(w), .x(x), .y(y), .z(z),
    .out_valid(vld8), .out_ready(out_ready), .A(a8), .B(b8), .err(err8),
    .cnt_clr(cnt_clr), .err_count(cnt8)
  );

  encoder42_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .w(w), .x(x), .y(y), .z(z),
    .out_valid(vld2), .out_ready(out_ready), .A(a2), .B(b2), .err(err2),
    .cnt_clr(cnt_clr), .err_count(cnt2)
  );

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  // Reference state: what the output register and counters should hold.
  logic        m_valid = 1'b0;
  int unsigned m_code  = 0;
  logic        m_err   = 1'b0;
  int unsigned m_cnt8  = 0;
  int unsigned m_cnt2  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned c, input int unsigned mx);
    return (c >= mx) ? mx : c + 1;
  endfunction

  // wxyz[3] is w (code 0) ... wxyz[0] is z (code 3).
  task automatic cyc(input logic iv, input logic [3:0] wxyz, input logic ordy,
                     input logic clr, input logic rr);
    logic [3:0]  lines;
    int unsigned code;
    int unsigned hot;
    logic        acc;
    lines = {wxyz[0], wxyz[1], wxyz[2], wxyz[3]};
    rst = rr; in_valid = iv; out_ready = ordy; cnt_clr = clr;
    w = wxyz[3]; x = wxyz[2]; y = wxyz[1]; z = wxyz[0];
    #1;
    chk("in_ready8", {31'd0, rdy8}, {31'd0, (!m_valid || ordy)});
    chk("in_ready2", {31'd0, rdy2}, {31'd0, (!m_valid || ordy)});
    @(posedge clk);
    code = 0;
    for (int unsigned i = 0; i < 4; i++) if (lines[i]) code = i;
    hot = $countones(lines);
    acc = iv && (!m_valid || ordy);
    if (rr) begin
      m_valid = 1'b0; m_code = 0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (clr) begin
        m_cnt8 = (acc && hot != 1) ? 1 : 0;
        m_cnt2 = m_cnt8;
      end else if (acc && hot != 1) begin
        m_cnt8 = sat_inc(m_cnt8, 255);
        m_cnt2 = sat_inc(m_cnt2, 3);
      end
      if (acc) begin
        m_valid = 1'b1; m_code = code; m_err = (hot != 1);
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid8", {31'd0, vld8}, {31'd0, m_valid});
    chk("AB8",        {30'd0, a8, b8}, m_code);
    chk("err8",       {31'd0, err8}, {31'd0, m_err});
    chk("err_count8", {24'd0, cnt8}, m_cnt8);
    chk("out_valid2", {31'd0, vld2}, {31'd0, m_valid});
    chk("AB2",        {30'd0, a2, b2}, m_code);
    chk("err2",       {31'd0, err2}, {31'd0, m_err});
    chk("err_count2", {30'd0, cnt2}, m_cnt2);
  endtask

  initial begin
    logic [1:0] ab;
    logic [3:0] oh;
    logic [3:0] seq_ab [4];
    // Reset state
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    // Clean one-hot codes back-to-back
    cyc(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    // Loop-back through a decoder24 model
    seq_ab[0] = 4'd0; seq_ab[1] = 4'd2; seq_ab[2] = 4'd3; seq_ab[3] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      ab = seq_ab[i][1:0];
      oh = 4'b1000 >> ab;
      cyc(1'b1, oh, 1'b1, 1'b0, 1'b0);
    end
    // Malformed inputs
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    // Backpressure
    cyc(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    // Saturation of the narrow counter, then clear with a coincident error
    repeat (5) cyc(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
    // Reset while FULL and stalled, with an in_valid in the reset cycle
    cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 49) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
